status_flag_unit: RTL and testbench

- Producer side of the NZCV status interface. Executes one data-processing operation per cycle on two WIDTH-bit operands and registers the result.
- When the S bit is set, computes Z/C/N/V and commits them into the architectural Status_Register.
- The registered Status_Register and a same-cycle forwarded copy feed the condition-check stage.
- Sits in the execute stage, between the ID/EX pipeline register and the EX/MEM register.

---
 rtl/status_flag_unit.sv | 109 ++++++++++
 tb/tb_status_flag_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/status_flag_unit.sv
// Execute-stage ALU that registers its result and maintains the NZCV status register,
// with a same-cycle forwarded copy of the flags for the condition-check stage.
module status_flag_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [3:0]       exe_cmd,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             freeze,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_result,
  output logic             result_valid,
  output logic [3:0]       Status_Register,
  output logic [3:0]       status_fwd
);

  localparam int unsigned RW  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] nb_ext;
  logic [WIDTH:0] res;
  logic           cin;
  logic           legal;
  logic           arith;
  logic           sub_op;
  logic           z_new;
  logic           c_new;
  logic           n_new;
  logic           v_new;
  logic           v_add;
  logic           v_sub;
  logic [3:0]     flags_new;
  logic           commit;

  assign a_ext  = {1'b0, val1};
  assign b_ext  = {1'b0, val2};
  assign nb_ext = {1'b0, ~val2};
  assign cin    = Status_Register[2];

  // Operation decode and WIDTH+1-bit datapath; bit WIDTH is the carry out
  always_comb begin
    legal  = 1'b1;
    arith  = 1'b0;
    sub_op = 1'b0;
    res    = '0;
    case (exe_cmd)
      CMD_MOV: res = b_ext;
      CMD_MVN: res = nb_ext;
      CMD_ADD: begin res = a_ext + b_ext;                 arith = 1'b1; end
      CMD_ADC: begin res = a_ext + b_ext + RW'(cin);      arith = 1'b1; end
      CMD_SUB: begin res = a_ext + nb_ext + RW'(1'b1);    arith = 1'b1; sub_op = 1'b1; end
      CMD_SBC: begin res = a_ext + nb_ext + RW'(cin);     arith = 1'b1; sub_op = 1'b1; end
      CMD_AND: res = a_ext & b_ext;
      CMD_ORR: res = a_ext | b_ext;
      CMD_EOR: res = a_ext ^ b_ext;
      default: legal = 1'b0;
    endcase
  end

  // Flag generation; C and V survive logical ops and moves
  always_comb begin
    z_new     = (res[MSB:0] == '0);
    n_new     = res[MSB];
    v_add     = (val1[MSB] == val2[MSB]) & (res[MSB] != val1[MSB]);
    v_sub     = (val1[MSB] != val2[MSB]) & (res[MSB] != val1[MSB]);
    c_new     = arith ? res[WIDTH] : Status_Register[2];
    v_new     = arith ? (sub_op ? v_sub : v_add) : Status_Register[0];
    flags_new = {z_new, c_new, n_new, v_new};
  end

  assign commit     = valid_in & ~freeze & ~flush & legal;
  assign status_fwd = (commit & s_bit) ? flags_new : Status_Register;

  // Flush dominates freeze; neither flushed nor illegal ops ever touch the flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result      <= '0;
      result_valid    <= 1'b0;
      Status_Register <= 4'b0000;
    end else if (flush) begin
      result_valid <= 1'b0;
    end else if (!freeze) begin
      if (commit) begin
        alu_result   <= res[MSB:0];
        result_valid <= 1'b1;
        if (s_bit) Status_Register <= flags_new;
      end else begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench for status_flag_unit: directed cases with literal expectations
// plus randomized traffic compared every cycle against an arithmetic reference model.
module tb_status_flag_unit;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic [3:0]    exe_cmd;
  logic          s_bit;
  logic [W-1:0]  val1;
  logic [W-1:0]  val2;
  logic          freeze;
  logic          flush;
  logic [W-1:0]  alu_result;
  logic          result_valid;
  logic [3:0]    Status_Register;
  logic [3:0]    status_fwd;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  logic [W-1:0] m_res;
  logic         m_valid;
  logic [3:0]   m_sr;

  status_flag_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .exe_cmd(exe_cmd), .s_bit(s_bit),
    .val1(val1), .val2(val2), .freeze(freeze), .flush(flush),
    .alu_result(alu_result), .result_valid(result_valid),
    .Status_Register(Status_Register), .status_fwd(status_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: results and flags from plain integer arithmetic on the operands
  function automatic void calc(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [3:0] sr, output logic legal,
                               output logic [W-1:0] res, output logic [3:0] fl);
    longint ua, ub, sa, sb, sres, cin;
    logic c, v, is_arith;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cin = longint'(sr[2]);
    legal = 1'b1; is_arith = 1'b0; c = sr[2]; v = sr[0]; res = '0; sres = 0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2: begin res = W'(ua + ub);       c = (ua + ub) > 64'hFFFF_FFFF;       sres = sa + sb;       is_arith = 1'b1; end
      4'd3: begin res = W'(ua + ub + cin); c = (ua + ub + cin) > 64'hFFFF_FFFF; sres = sa + sb + cin; is_arith = 1'b1; end
      4'd4: begin res = W'(ua - ub);       c = ua >= ub;                        sres = sa - sb;       is_arith = 1'b1; end
      4'd5: begin res = W'(ua - ub - 1 + cin); c = ua >= ub + 1 - cin;          sres = sa - sb - 1 + cin; is_arith = 1'b1; end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: legal = 1'b0;
    endcase
    if (is_arith) v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    fl = {res == '0, c, res[W-1], v};
  endfunction

  // Architectural state of the model, advanced once per clock edge
  always @(posedge clk or negedge rst) begin
    logic lg; logic [W-1:0] r; logic [3:0] f;
    if (!rst) begin
      m_res = '0; m_valid = 1'b0; m_sr = 4'b0000;
    end else begin
      calc(exe_cmd, val1, val2, m_sr, lg, r, f);
      if (flush) m_valid = 1'b0;
      else if (!freeze) begin
        if (valid_in && lg) begin
          m_res = r; m_valid = 1'b1;
          if (s_bit) m_sr = f;
        end else m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison on the falling edge
  always @(negedge clk) begin
    logic lg; logic [W-1:0] r; logic [3:0] f; logic [3:0] efwd;
    if (chk_en) begin
      calc(exe_cmd, val1, val2, m_sr, lg, r, f);
      efwd = (valid_in && !freeze && !flush && lg && s_bit) ? f : m_sr;
      chk("model_alu_result", 64'(alu_result), 64'(m_res));
      chk("model_result_valid", 64'(result_valid), 64'(m_valid));
      chk("model_status_reg", 64'(Status_Register), 64'(m_sr));
      chk("model_status_fwd", 64'(status_fwd), 64'(efwd));
    end
  end

  task automatic set_in(input logic v, input logic [3:0] cmd, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic frz, input logic fl);
    valid_in = v; exe_cmd = cmd; s_bit = s; val1 = a; val2 = b; freeze = frz; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic [3:0] cmd, input logic s,
                    input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic frz, input logic fl);
    set_in(v, cmd, s, a, b, frz, fl);
    tick();
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst = 1'b0;
    set_in(1'b0, 4'd0, 1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    chk("reset_alu", 64'(alu_result), 64'h0);
    chk("reset_valid", 64'(result_valid), 64'h0);
    chk("reset_sr", 64'(Status_Register), 64'h0);
    rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // ADD overflow into sign bit
    op(1'b1, 4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("add_result", 64'(alu_result), 64'h8000_0000);
    chk("add_sr", 64'(Status_Register), 64'h3);
    chk("add_valid", 64'(result_valid), 64'h1);

    // CMP equal sets Z and C, then ADC consumes the carry
    op(1'b1, 4'b0100, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
    chk("cmp_sr", 64'(Status_Register), 64'hC);
    op(1'b1, 4'b0011, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
    chk("adc_result", 64'(alu_result), 64'd3);

    // Clear C, then SBC 0-0 borrows
    op(1'b1, 4'b0010, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("clrc_sr", 64'(Status_Register), 64'h8);
    op(1'b1, 4'b0101, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("sbc_result", 64'(alu_result), 64'hFFFF_FFFF);
    chk("sbc_sr", 64'(Status_Register), 64'h2);

    // Forwarding of about-to-be-written flags, and passthrough without S
    set_in(1'b1, 4'b0110, 1'b1, 32'hF0, 32'h0F, 1'b0, 1'b0);
    #1;
    chk("fwd_and_s", 64'(status_fwd), 64'h8);
    tick();
    chk("and_sr", 64'(Status_Register), 64'h8);
    set_in(1'b1, 4'b0110, 1'b0, 32'hFF, 32'hFF, 1'b0, 1'b0);
    #1;
    chk("fwd_and_nos", 64'(status_fwd), 64'h8);
    tick();

    // Freeze holds everything for three cycles
    op(1'b1, 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("wrap_result", 64'(alu_result), 64'h0);
    chk("wrap_sr", 64'(Status_Register), 64'hC);
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 4'b0100, 1'b1, 32'd1, 32'd2, 1'b1, 1'b0);
      chk("frz_result", 64'(alu_result), 64'h0);
      chk("frz_valid", 64'(result_valid), 64'h1);
      chk("frz_sr", 64'(Status_Register), 64'hC);
    end
    op(1'b1, 4'b0100, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
    chk("unfrz_result", 64'(alu_result), 64'hFFFF_FFFF);
    chk("unfrz_sr", 64'(Status_Register), 64'h2);

    // Flush kills an S-op
    op(1'b1, 4'b0010, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("flush_valid", 64'(result_valid), 64'h0);
    chk("flush_sr", 64'(Status_Register), 64'h2);
    chk("flush_result", 64'(alu_result), 64'hFFFF_FFFF);

    // Flush together with freeze still drops result_valid
    op(1'b1, 4'b0001, 1'b0, 32'd0, 32'd5, 1'b0, 1'b0);
    chk("mov_result", 64'(alu_result), 64'd5);
    op(1'b1, 4'b0001, 1'b1, 32'd0, 32'd9, 1'b1, 1'b1);
    chk("flfrz_valid", 64'(result_valid), 64'h0);
    chk("flfrz_result", 64'(alu_result), 64'd5);

    // Illegal command
    op(1'b1, 4'b0001, 1'b0, 32'd0, 32'd7, 1'b0, 1'b0);
    op(1'b1, 4'b1111, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("illegal_valid", 64'(result_valid), 64'h0);
    chk("illegal_sr", 64'(Status_Register), 64'h2);
    chk("illegal_result", 64'(alu_result), 64'd7);

    // Asynchronous reset mid-cycle
    op(1'b1, 4'b0100, 1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_sr", 64'(Status_Register), 64'h0);
    chk("async_rst_valid", 64'(result_valid), 64'h0);
    chk("async_rst_result", 64'(alu_result), 64'h0);
    rst = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h7FFF_FFFF + W'($urandom_range(0, 2));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = a;
        default: b = $urandom;
      endcase
      set_in($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             a, b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #1;
        rst = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
